// File: rtl/soc_reset_sequencer_pkg.sv
// State encoding and elaboration-time helpers shared by the mini16 reset sequencer.
// Counter widths and group counts are derived here so every file sizes them the same way.
package mini16_rst_pkg;

   localparam int STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      S_WAIT_LOCK = 3'd0,
      S_PERIPH    = 3'd1,
      S_CORES     = 3'd2,
      S_RUN       = 3'd3
   } seq_state_e;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int v = value - 1; v > 0; v = v >> 1) result++;
      return result;
   endfunction

   function automatic int num_groups(input int cores, input int group_size);
      return (cores + group_size - 1) / group_size;
   endfunction

   // Width of a counter holding 0..count-1, never narrower than one bit.
   function automatic int cnt_width(input int count);
      return (clog2(count) < 1) ? 1 : clog2(count);
   endfunction

endpackage

// File: rtl/soc_reset_sequencer_sync_debounce.sv
// Two-flop synchronizer followed by a stable-count debouncer: the output level only
// follows the synchronized input once it has disagreed for DEBOUNCE_CYCLES cycles in a row.
module sync_debounce
   import mini16_rst_pkg::*;
#(
   parameter int   DEBOUNCE_CYCLES = 65536,
   parameter logic RESET_VALUE     = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic i_raw,
   output logic o_level
);

   localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);

   logic             r_meta;
   logic             r_sync;
   logic             r_level;
   logic [CNT_W-1:0] r_cnt;

   // NOTE: non-blocking assignments so r_sync takes r_meta's pre-edge value (a true two-stage chain).
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
      end else begin
         r_meta <= i_raw;
         r_sync <= r_meta;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_level <= RESET_VALUE;
         r_cnt   <= '0;
      end else if (r_sync == r_level) begin
         r_cnt   <= '0;
      end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
         r_level <= r_sync;
         r_cnt   <= '0;
      end else begin
         r_cnt   <= r_cnt + 1'b1;
      end
   end

   assign o_level = r_level;

endmodule

// File: rtl/soc_reset_sequencer.sv
// Reset release sequencer for mini16: filters PLL lock, debounces the soft-reset button,
// releases the peripheral reset and then the core resets in staggered groups.
module soc_reset_sequencer
   import mini16_rst_pkg::*;
#(
   parameter int CORES              = 128,
   parameter int GROUP_SIZE         = 16,
   parameter int LOCK_FILTER_CYCLES = 1024,
   parameter int PERIPH_CYCLES      = 256,
   parameter int STAGGER_CYCLES     = 64,
   parameter int DEBOUNCE_CYCLES    = 65536
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               pll_locked,
   input  logic               btn_reset_n,
   output logic               periph_reset,
   output logic [CORES-1:0]   core_reset,
   output logic               ready,
   output logic [STATE_W-1:0] seq_state
);

   localparam int GROUPS   = num_groups(CORES, GROUP_SIZE);
   localparam int CNT_MAX1 = (LOCK_FILTER_CYCLES > PERIPH_CYCLES) ? LOCK_FILTER_CYCLES : PERIPH_CYCLES;
   localparam int CNT_MAX  = (CNT_MAX1 > STAGGER_CYCLES) ? CNT_MAX1 : STAGGER_CYCLES;
   localparam int CNT_W    = cnt_width(CNT_MAX);
   localparam int GRP_W    = cnt_width(GROUPS + 1);

   logic             r_lock_meta;
   logic             r_lock_s;
   logic             w_btn_level;
   logic             w_abort;

   seq_state_e       r_state,  w_state_nxt;
   logic [CNT_W-1:0] r_cnt,    w_cnt_nxt;
   logic [GRP_W-1:0] r_grp,    w_grp_nxt;
   logic             r_periph, w_periph_nxt;
   logic [CORES-1:0] r_core,   w_core_nxt;
   logic             r_ready,  w_ready_nxt;
   logic [GRP_W-1:0] w_sel_grp;
   logic [CORES-1:0] w_grp_mask;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_lock_meta <= 1'b0;
         r_lock_s    <= 1'b0;
      end else begin
         r_lock_meta <= pll_locked;
         r_lock_s    <= r_lock_meta;
      end
   end

   sync_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_VALUE     (1'b1)
   ) u_btn_debounce (
      .clk     (clk),
      .reset   (reset),
      .i_raw   (btn_reset_n),
      .o_level (w_btn_level)
   );

   assign w_abort = !r_lock_s || !w_btn_level;

   // Group 0 is released from S_PERIPH; later groups use the running group index.
   assign w_sel_grp = (r_state == S_CORES) ? r_grp : '0;

   always_comb begin
      w_grp_mask = '0;
      for (int i = 0; i < CORES; i++) begin
         w_grp_mask[i] = (GRP_W'(i / GROUP_SIZE) == w_sel_grp);
      end
   end

   // NOTE: every next-value signal is given its hold value first so no latch can be inferred.
   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_grp_nxt    = r_grp;
      w_periph_nxt = r_periph;
      w_core_nxt   = r_core;
      w_ready_nxt  = r_ready;

      if ((r_state != S_WAIT_LOCK) && w_abort) begin
         w_state_nxt  = S_WAIT_LOCK;
         w_cnt_nxt    = '0;
         w_grp_nxt    = '0;
         w_periph_nxt = 1'b1;
         w_core_nxt   = '1;
         w_ready_nxt  = 1'b0;
      end else begin
         case (r_state)
            S_WAIT_LOCK: begin
               if (w_abort) begin
                  w_cnt_nxt = '0;
               end else if (r_cnt == CNT_W'(LOCK_FILTER_CYCLES - 1)) begin
                  w_state_nxt  = S_PERIPH;
                  w_periph_nxt = 1'b0;
                  w_cnt_nxt    = '0;
               end else begin
                  w_cnt_nxt = r_cnt + 1'b1;
               end
            end
            S_PERIPH: begin
               if (r_cnt == CNT_W'(PERIPH_CYCLES - 1)) begin
                  w_core_nxt = r_core & ~w_grp_mask;
                  w_grp_nxt  = GRP_W'(1);
                  w_cnt_nxt  = '0;
                  if (GROUPS == 1) begin
                     w_state_nxt = S_RUN;
                     w_ready_nxt = 1'b1;
                  end else begin
                     w_state_nxt = S_CORES;
                  end
               end else begin
                  w_cnt_nxt = r_cnt + 1'b1;
               end
            end
            S_CORES: begin
               if (r_cnt == CNT_W'(STAGGER_CYCLES - 1)) begin
                  w_core_nxt = r_core & ~w_grp_mask;
                  w_grp_nxt  = r_grp + 1'b1;
                  w_cnt_nxt  = '0;
                  if (r_grp == GRP_W'(GROUPS - 1)) begin
                     w_state_nxt = S_RUN;
                     w_ready_nxt = 1'b1;
                  end
               end else begin
                  w_cnt_nxt = r_cnt + 1'b1;
               end
            end
            S_RUN: begin
            end
            default: begin
               w_state_nxt = S_WAIT_LOCK;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= S_WAIT_LOCK;
         r_cnt    <= '0;
         r_grp    <= '0;
         r_periph <= 1'b1;
         r_core   <= '1;
         r_ready  <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_grp    <= w_grp_nxt;
         r_periph <= w_periph_nxt;
         r_core   <= w_core_nxt;
         r_ready  <= w_ready_nxt;
      end
   end

   assign periph_reset = r_periph;
   assign core_reset   = r_core;
   assign ready        = r_ready;
   assign seq_state    = r_state;

endmodule

// File: tb/tb_soc_reset_sequencer.sv
// Bench for soc_reset_sequencer: scenario tasks plus a randomized run, all checked against a
// model that tracks how many consecutive healthy edges have passed since the last abort.
`timescale 1ns/1ps
module tb_soc_reset_sequencer;

   localparam int CORES  = 8;
   localparam int GS     = 3;
   localparam int LOCK   = 4;
   localparam int PER    = 2;
   localparam int STG    = 3;
   localparam int DEB    = 4;
   localparam int GROUPS = (CORES + GS - 1) / GS;

   logic             clk = 1'b0;
   logic             reset;
   logic             pll_locked;
   logic             btn_reset_n;
   logic             periph_reset;
   logic [CORES-1:0] core_reset;
   logic             ready;
   logic [2:0]       seq_state;

   int n_vec = 0;
   int n_err = 0;

   // Model: synchronizer pipelines, debounced button, and the healthy-edge run length.
   int m_run;
   bit m_lock1, m_lock2, m_btn1, m_btn2, m_deb;
   int m_diff;

   always #5 clk = ~clk;

   soc_reset_sequencer #(
      .CORES              (CORES),
      .GROUP_SIZE         (GS),
      .LOCK_FILTER_CYCLES (LOCK),
      .PERIPH_CYCLES      (PER),
      .STAGGER_CYCLES     (STG),
      .DEBOUNCE_CYCLES    (DEB)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .pll_locked   (pll_locked),
      .btn_reset_n  (btn_reset_n),
      .periph_reset (periph_reset),
      .core_reset   (core_reset),
      .ready        (ready),
      .seq_state    (seq_state)
   );

   task automatic model_reset();
      m_run = 0;  m_lock1 = 0; m_lock2 = 0;
      m_btn1 = 0; m_btn2 = 0;  m_deb = 1;   m_diff = 0;
   endtask

   function automatic int model_groups();
      int g;
      if (m_run < LOCK + PER) return 0;
      g = 1 + (m_run - LOCK - PER) / STG;
      return (g > GROUPS) ? GROUPS : g;
   endfunction

   function automatic logic [12:0] model_vec();
      int ng;
      logic [CORES-1:0] core;
      logic [2:0] st;
      ng = model_groups();
      for (int i = 0; i < CORES; i++) core[i] = ((i / GS) >= ng);
      if (m_run < LOCK)            st = 3'd0;
      else if (m_run < LOCK + PER) st = 3'd1;
      else if (ng < GROUPS)        st = 3'd2;
      else                         st = 3'd3;
      return {(m_run < LOCK), core, (ng == GROUPS), st};
   endfunction

   function automatic logic [12:0] dut_vec();
      return {periph_reset, core_reset, ready, seq_state};
   endfunction

   // Called at a falling edge with inputs already set; returns at the next falling edge.
   task automatic step();
      bit abort;
      @(posedge clk);
      abort = !m_lock2 || !m_deb;
      m_run = abort ? 0 : ((m_run < 100000) ? m_run + 1 : m_run);
      if (m_btn2 != m_deb) begin
         m_diff++;
         if (m_diff == DEB) begin
            m_deb  = m_btn2;
            m_diff = 0;
         end
      end else begin
         m_diff = 0;
      end
      m_lock2 = m_lock1; m_lock1 = pll_locked;
      m_btn2  = m_btn1;  m_btn1  = btn_reset_n;
      @(negedge clk);
   endtask

   task automatic idle_steps(input string tag, input int n);
      pll_locked = 1'b0;
      for (int i = 0; i < n; i++) begin
         step();
         n_vec++;
         if (dut_vec() !== model_vec()) begin
            n_err++;
            $display("FAIL %s idle %0d: got %h expected %h", tag, i, dut_vec(), model_vec());
         end
      end
   endtask

   // Raises pll_locked and records the edge numbers of each visible release step.
   task automatic run_sequence(input string tag, output int e_per, output int e_f8,
                               output int e_c0, output int e_done);
      e_per = 0; e_f8 = 0; e_c0 = 0; e_done = 0;
      pll_locked = 1'b1;
      for (int e = 1; (e <= 30) && (e_done == 0); e++) begin
         step();
         n_vec++;
         if (dut_vec() !== model_vec()) begin
            n_err++;
            $display("FAIL %s edge %0d: got %h expected %h", tag, e, dut_vec(), model_vec());
         end
         if ((e_per == 0) && (periph_reset === 1'b0)) e_per = e;
         if ((e_f8 == 0) && (core_reset === 8'hF8)) e_f8 = e;
         if ((e_c0 == 0) && (core_reset === 8'hC0)) e_c0 = e;
         if ((core_reset === 8'h00) && (ready === 1'b1) && (seq_state === 3'd3)) e_done = e;
      end
   endtask

   task automatic check_timing(input string tag, input int e_per, input int e_f8,
                               input int e_c0, input int e_done);
      n_vec++;
      if (e_per !== 6)   begin n_err++; $display("FAIL %s periph_edge: got %0d expected 6", tag, e_per); end
      n_vec++;
      if (e_f8 !== 8)    begin n_err++; $display("FAIL %s f8_edge: got %0d expected 8", tag, e_f8); end
      n_vec++;
      if (e_c0 !== 11)   begin n_err++; $display("FAIL %s c0_edge: got %0d expected 11", tag, e_c0); end
      n_vec++;
      if (e_done !== 14) begin n_err++; $display("FAIL %s ready_edge: got %0d expected 14", tag, e_done); end
   endtask

   task automatic test_reset();
      reset = 1'b1; pll_locked = 1'b0; btn_reset_n = 1'b1;
      model_reset();
      repeat (3) @(negedge clk);
      n_vec++;
      if (dut_vec() !== {1'b1, 8'hFF, 1'b0, 3'd0}) begin
         n_err++;
         $display("FAIL reset_values: got %h expected %h", dut_vec(), {1'b1, 8'hFF, 1'b0, 3'd0});
      end
      reset = 1'b0;
   endtask

   task automatic test_powerup();
      int e_per, e_f8, e_c0, e_done;
      run_sequence("powerup", e_per, e_f8, e_c0, e_done);
      check_timing("powerup", e_per, e_f8, e_c0, e_done);
   endtask

   task automatic test_lock_glitch();
      int e_fall;
      idle_steps("glitch_pre", 4);
      pll_locked = 1'b1;
      repeat (2) step();
      pll_locked = 1'b0;
      repeat (5) step();
      pll_locked = 1'b1;
      e_fall = 0;
      for (int e = 1; (e <= 20) && (e_fall == 0); e++) begin
         step();
         n_vec++;
         if (dut_vec() !== model_vec()) begin
            n_err++;
            $display("FAIL glitch edge %0d: got %h expected %h", e, dut_vec(), model_vec());
         end
         if (periph_reset === 1'b0) e_fall = e;
      end
      n_vec++;
      if (e_fall !== 6) begin
         n_err++;
         $display("FAIL glitch_refilter: periph fell at edge %0d expected 6", e_fall);
      end
   endtask

   task automatic test_lock_loss();
      int e_per, e_f8, e_c0, e_done;
      idle_steps("loss_pre", 4);
      pll_locked = 1'b1;
      repeat (8) step();
      n_vec++;
      if (core_reset !== 8'hF8) begin
         n_err++; $display("FAIL loss_f8: got %h expected f8", core_reset);
      end
      pll_locked = 1'b0;
      repeat (2) step();
      n_vec++;
      if (seq_state !== 3'd2) begin
         n_err++; $display("FAIL loss_early: state %0d expected 2", seq_state);
      end
      step();
      n_vec++;
      if (dut_vec() !== {1'b1, 8'hFF, 1'b0, 3'd0}) begin
         n_err++;
         $display("FAIL loss_abort: got %h expected %h", dut_vec(), {1'b1, 8'hFF, 1'b0, 3'd0});
      end
      idle_steps("loss_idle", 3);
      run_sequence("relock", e_per, e_f8, e_c0, e_done);
      check_timing("relock", e_per, e_f8, e_c0, e_done);
   endtask

   task automatic test_button_bounce();
      int e_abort, e_fall;
      for (int r = 0; r < 5; r++) begin
         for (int c = 0; c < 4; c++) begin
            btn_reset_n = (c == 3);
            step();
            n_vec++;
            if (dut_vec() !== model_vec()) begin
               n_err++;
               $display("FAIL bounce r%0d c%0d: got %h expected %h", r, c, dut_vec(), model_vec());
            end
         end
      end
      n_vec++;
      if ((ready !== 1'b1) || (seq_state !== 3'd3)) begin
         n_err++; $display("FAIL bounce_ready: ready %b state %0d expected 1/3", ready, seq_state);
      end
      btn_reset_n = 1'b0;
      e_abort = 0;
      for (int e = 1; e <= 50; e++) begin
         step();
         n_vec++;
         if (dut_vec() !== model_vec()) begin
            n_err++;
            $display("FAIL btn_hold edge %0d: got %h expected %h", e, dut_vec(), model_vec());
         end
         if ((e_abort == 0) && (periph_reset === 1'b1)) e_abort = e;
      end
      n_vec++;
      if (e_abort !== 7) begin
         n_err++; $display("FAIL btn_abort_edge: got %0d expected 7", e_abort);
      end
      n_vec++;
      if (dut_vec() !== {1'b1, 8'hFF, 1'b0, 3'd0}) begin
         n_err++;
         $display("FAIL btn_held: got %h expected %h", dut_vec(), {1'b1, 8'hFF, 1'b0, 3'd0});
      end
      btn_reset_n = 1'b1;
      e_fall = 0;
      for (int e = 1; (e <= 30) && (e_fall == 0); e++) begin
         step();
         n_vec++;
         if (dut_vec() !== model_vec()) begin
            n_err++;
            $display("FAIL btn_release edge %0d: got %h expected %h", e, dut_vec(), model_vec());
         end
         if (periph_reset === 1'b0) e_fall = e;
      end
      n_vec++;
      if (e_fall !== 10) begin
         n_err++; $display("FAIL btn_release_edge: got %0d expected 10", e_fall);
      end
   endtask

   task automatic test_async_reset();
      n_vec++;
      if (seq_state !== 3'd1) begin
         n_err++; $display("FAIL async_pre: state %0d expected 1", seq_state);
      end
      #3 reset = 1'b1;
      #1;
      n_vec++;
      if (dut_vec() !== {1'b1, 8'hFF, 1'b0, 3'd0}) begin
         n_err++;
         $display("FAIL async_reset: got %h expected %h", dut_vec(), {1'b1, 8'hFF, 1'b0, 3'd0});
      end
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      for (int e = 1; e <= 4; e++) begin
         step();
         n_vec++;
         if (dut_vec() !== model_vec()) begin
            n_err++;
            $display("FAIL async_after edge %0d: got %h expected %h", e, dut_vec(), model_vec());
         end
      end
   endtask

   task automatic test_abort_priority();
      idle_steps("prio_pre", 3);
      pll_locked = 1'b1;
      repeat (11) step();
      n_vec++;
      if (core_reset !== 8'hC0) begin
         n_err++; $display("FAIL prio_c0: got %h expected c0", core_reset);
      end
      pll_locked = 1'b0;
      repeat (2) step();
      n_vec++;
      if (dut_vec() !== {1'b0, 8'hC0, 1'b0, 3'd2}) begin
         n_err++;
         $display("FAIL prio_edge13: got %h expected %h", dut_vec(), {1'b0, 8'hC0, 1'b0, 3'd2});
      end
      step();
      n_vec++;
      if (dut_vec() !== {1'b1, 8'hFF, 1'b0, 3'd0}) begin
         n_err++;
         $display("FAIL prio_abort_wins: got %h expected %h", dut_vec(), {1'b1, 8'hFF, 1'b0, 3'd0});
      end
   endtask

   task automatic test_random();
      int r;
      pll_locked  = 1'b1;
      btn_reset_n = 1'b1;
      for (int i = 0; i < 800; i++) begin
         r = $urandom_range(0, 99);
         if (r < 2)      pll_locked  = ~pll_locked;
         else if (r < 4) btn_reset_n = ~btn_reset_n;
         else if ((r < 6) && !btn_reset_n) btn_reset_n = 1'b1;
         step();
         n_vec++;
         if (dut_vec() !== model_vec()) begin
            n_err++;
            $display("FAIL random cycle %0d: got %h expected %h", i, dut_vec(), model_vec());
         end
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_powerup();
      test_lock_glitch();
      test_lock_loss();
      test_button_bounce();
      test_async_reset();
      test_abort_priority();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
